// File: rtl/data_mem_stage_if.sv
// MEM-stage data memory bus: request from the pipeline, load result and status back.
// The master side is the pipeline/testbench; the slave side is data_mem_stage.
interface data_mem_stage_if;
    logic        mem_en;
    logic [2:0]  mem_op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic [31:0] rdata;
    logic        rvalid;
    logic        addr_err;
    logic        busy;

    modport master (
        output mem_en, mem_op, addr, wdata, pc,
        input  rdata, rvalid, addr_err, busy
    );

    modport slave (
        input  mem_en, mem_op, addr, wdata, pc,
        output rdata, rvalid, addr_err, busy
    );
endinterface

// File: rtl/data_mem_stage.sv
// MIPS MEM-stage data memory: word/half/byte loads and stores on a word RAM, with post-reset clear.
// Define DM_TRACE_EN to print a simulation trace of every committed store.
module data_mem_stage #(
    parameter int          ADDR_W    = 12,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset_n,
    data_mem_stage_if.slave bus
);
    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_SW  = 3'd1;
    localparam logic [2:0] OP_LH  = 3'd2;
    localparam logic [2:0] OP_LHU = 3'd3;
    localparam logic [2:0] OP_SH  = 3'd4;
    localparam logic [2:0] OP_LB  = 3'd5;
    localparam logic [2:0] OP_LBU = 3'd6;
    localparam int         DEPTH  = 1 << ADDR_W;

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_clr_ptr;
    logic [ADDR_W-1:0]   w_clr_ptr_next;
    logic                w_clearing;

    logic [32:0]         w_off_ext;
    logic                w_out_range;
    logic [ADDR_W-1:0]   w_idx;
    logic [1:0]          w_lane;
    logic [ADDR_W-1:0]   w_wr_idx;

    logic                w_is_load;
    logic                w_is_store;
    logic                w_misalign;
    logic                w_reserved;
    logic                w_accept;
    logic                w_err;
    logic                w_ld_ok;
    logic                w_st_ok;
    logic [3:0]          w_st_be;

    logic [31:0]         w_rd_word;
    logic                r_has_data;
    logic [2:0]          r_ld_op;
    logic [1:0]          r_ld_lane;
    logic                r_rvalid;
    logic                r_addr_err;
    logic [15:0]         w_half;
    logic [7:0]          w_byte;
    logic [31:0]         w_rdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_CLEAR;
            r_clr_ptr <= '0;
        end else begin
            r_state   <= w_state_next;
            r_clr_ptr <= w_clr_ptr_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_clr_ptr_next = r_clr_ptr;
        w_clearing     = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_clearing     = 1'b1;
                w_clr_ptr_next = r_clr_ptr + ADDR_W'(1);
                if (&r_clr_ptr) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                w_state_next = ST_RUN;
            end
            default: begin
                w_state_next = ST_CLEAR;
            end
        endcase
    end

    // 33-bit subtraction so an address below BASE_ADDR shows up as a borrow instead of wrapping.
    assign w_off_ext   = {1'b0, bus.addr} - {1'b0, BASE_ADDR};
    assign w_out_range = w_off_ext[32] | (|w_off_ext[31:ADDR_W+2]);
    assign w_idx       = w_off_ext[ADDR_W+1:2];
    assign w_lane      = w_off_ext[1:0];
    assign w_wr_idx    = w_clearing ? r_clr_ptr : w_idx;

    // The opcode map has no byte-store encoding; code 7 is rejected as reserved.
    always_comb begin
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        w_misalign = 1'b0;
        w_reserved = 1'b0;
        case (bus.mem_op)
            OP_LW: begin
                w_is_load  = 1'b1;
                w_misalign = |w_lane;
            end
            OP_SW: begin
                w_is_store = 1'b1;
                w_misalign = |w_lane;
            end
            OP_LH, OP_LHU: begin
                w_is_load  = 1'b1;
                w_misalign = w_lane[0];
            end
            OP_SH: begin
                w_is_store = 1'b1;
                w_misalign = w_lane[0];
            end
            OP_LB, OP_LBU: begin
                w_is_load  = 1'b1;
            end
            default: begin
                w_reserved = 1'b1;
            end
        endcase
    end

    assign w_accept = (r_state == ST_RUN) & bus.mem_en;
    assign w_err    = w_accept & (w_out_range | w_misalign | w_reserved);
    assign w_ld_ok  = w_accept & ~w_err & w_is_load;
    assign w_st_ok  = w_accept & ~w_err & w_is_store;

    always_comb begin
        w_st_be = 4'b0000;
        if (w_st_ok) begin
            if (bus.mem_op == OP_SW) begin
                w_st_be = 4'b1111;
            end else begin
                w_st_be = w_lane[1] ? 4'b1100 : 4'b0011;
            end
        end
    end

    // One byte-wide RAM per lane gives per-byte write enables without read-modify-write.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] r_bank [DEPTH];
            logic [7:0] r_rd_byte;
            logic [7:0] w_wbyte;
            logic       w_we;

            assign w_wbyte = w_clearing             ? 8'h00 :
                             (bus.mem_op == OP_SW)  ? bus.wdata[gi*8 +: 8] :
                                                      bus.wdata[(gi % 2)*8 +: 8];
            assign w_we    = w_clearing | w_st_be[gi];

            always_ff @(posedge clk) begin
                if (w_we) begin
                    r_bank[w_wr_idx] <= w_wbyte;
                end
                if (w_ld_ok) begin
                    r_rd_byte <= r_bank[w_idx];
                end
            end

            assign w_rd_word[gi*8 +: 8] = r_rd_byte;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_has_data <= 1'b0;
            r_ld_op    <= OP_LW;
            r_ld_lane  <= 2'b00;
            r_rvalid   <= 1'b0;
            r_addr_err <= 1'b0;
        end else begin
            r_rvalid   <= w_ld_ok;
            r_addr_err <= w_err;
            if (w_ld_ok) begin
                r_has_data <= 1'b1;
                r_ld_op    <= bus.mem_op;
                r_ld_lane  <= w_lane;
            end
        end
    end

    // Extension runs after the RAM output register; rdata holds because that register only loads on a legal load.
    assign w_half = r_ld_lane[1] ? w_rd_word[31:16] : w_rd_word[15:0];

    always_comb begin
        w_byte = w_rd_word[7:0];
        case (r_ld_lane)
            2'd1:    w_byte = w_rd_word[15:8];
            2'd2:    w_byte = w_rd_word[23:16];
            2'd3:    w_byte = w_rd_word[31:24];
            default: w_byte = w_rd_word[7:0];
        endcase
    end

    always_comb begin
        w_rdata = '0;
        case (r_ld_op)
            OP_LW:   w_rdata = w_rd_word;
            OP_LH:   w_rdata = {{16{w_half[15]}}, w_half};
            OP_LHU:  w_rdata = {16'h0000, w_half};
            OP_LB:   w_rdata = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  w_rdata = {24'h000000, w_byte};
            default: w_rdata = '0;
        endcase
    end

    assign bus.rdata    = r_has_data ? w_rdata : 32'h0000_0000;
    assign bus.rvalid   = r_rvalid;
    assign bus.addr_err = r_addr_err;
    assign bus.busy     = (r_state == ST_CLEAR);

`ifdef DM_TRACE_EN
    logic [31:0] w_new_word;

    generate
        for (gi = 0; gi < 4; gi++) begin : g_trace
            assign w_new_word[gi*8 +: 8] = w_st_be[gi] ? g_lane[gi].w_wbyte
                                                       : g_lane[gi].r_bank[w_idx];
        end
    endgenerate

    always @(posedge clk) begin
        if (reset_n && w_st_ok) begin
            $display("@%08h: *%08h <= %08h", bus.pc, {bus.addr[31:2], 2'b00}, w_new_word);
        end
    end
`else
    logic w_unused;
    assign w_unused = ^bus.pc;
`endif

endmodule

// File: tb/tb_data_mem_stage.sv
// Self-checking bench for data_mem_stage: directed vector table, random ops against a byte-array model,
// and reset-during-load / reset-during-clear sequences.
module tb_data_mem_stage;
    localparam int          ADDR_W = 12;
    localparam int          DEPTH  = 1 << ADDR_W;
    localparam int          NBYTES = 4 * DEPTH;
    localparam logic [31:0] BASE   = 32'h0000_0000;

    localparam logic [2:0] LW = 3'd0, SW = 3'd1, LH = 3'd2, LHU = 3'd3;
    localparam logic [2:0] SH = 3'd4, LB = 3'd5, LBU = 3'd6, RSV = 3'd7;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;
    int   step;

    data_mem_stage_if bus ();

    data_mem_stage #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: flat little-endian byte memory plus the last returned load value.
    logic [7:0]  mdl [NBYTES];
    logic        m_valid;
    logic        m_err;
    logic [31:0] m_rdata;

    typedef struct {
        logic        en;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_valid;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [26];

    function automatic vec_t mk(input logic en, input logic [2:0] op, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic ev, input logic ee,
                                input logic [31:0] er);
        vec_t v;
        v.en = en; v.op = op; v.addr = addr; v.wdata = wdata;
        v.exp_valid = ev; v.exp_err = ee; v.exp_rdata = er;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NBYTES; i++) mdl[i] = 8'h00;
        m_rdata = 32'h0;
        m_valid = 1'b0;
        m_err   = 1'b0;
    endtask

    task automatic model_op(input logic en, input logic [2:0] op, input logic [31:0] addr,
                            input logic [31:0] wdata);
        int     size;
        bit     sgn;
        bit     ld;
        longint off;
        longint v;
        m_valid = 1'b0;
        m_err   = 1'b0;
        if (!en) return;
        size = 1; sgn = 0; ld = 0;
        case (op)
            LW:  begin size = 4; ld = 1; end
            SW:  size = 4;
            LH:  begin size = 2; ld = 1; sgn = 1; end
            LHU: begin size = 2; ld = 1; end
            SH:  size = 2;
            LB:  begin size = 1; ld = 1; sgn = 1; end
            LBU: begin size = 1; ld = 1; end
            default: size = 1;
        endcase
        off = longint'(addr) - longint'(BASE);
        if (op == RSV || off < 0 || off >= NBYTES || (off % size) != 0) begin
            m_err = 1'b1;
        end else if (!ld) begin
            for (int k = 0; k < size; k++) mdl[int'(off) + k] = 8'(wdata >> (8 * k));
        end else begin
            v = 0;
            for (int k = 0; k < size; k++) v = v + (longint'(mdl[int'(off) + k]) << (8 * k));
            if (sgn && v >= (longint'(1) << (8 * size - 1))) v = v - (longint'(1) << (8 * size));
            m_rdata = 32'(v);
            m_valid = 1'b1;
        end
    endtask

    // Drive one request at a negedge, let one rising edge pass, return at the following negedge.
    task automatic apply(input logic en, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata);
        bus.mem_en = en;
        bus.mem_op = op;
        bus.addr   = addr;
        bus.wdata  = wdata;
        bus.pc     = 32'h0040_0000 + 32'(step * 4);
        step++;
        model_op(en, op, addr, wdata);
        @(posedge clk);
        @(negedge clk);
        bus.mem_en = 1'b0;
    endtask

    // Count busy cycles from a reset release while hammering requests that must all be ignored.
    task automatic wait_clear(input string tag);
        int n;
        bit quiet;
        n = 0;
        quiet = 1'b1;
        while (bus.busy === 1'b1 && n < 2 * DEPTH) begin
            n++;
            if (bus.rvalid !== 1'b0 || bus.addr_err !== 1'b0) quiet = 1'b0;
            bus.mem_en = 1'b1;
            case (n % 3)
                0:       begin bus.mem_op = LW;  bus.addr = 32'h10; end
                1:       begin bus.mem_op = SW;  bus.addr = 32'h10; bus.wdata = 32'hDEAD_BEEF; end
                default: begin bus.mem_op = RSV; bus.addr = 32'h10; end
            endcase
            @(negedge clk);
        end
        if (bus.rvalid !== 1'b0 || bus.addr_err !== 1'b0) quiet = 1'b0;
        bus.mem_en = 1'b0;
        check({tag, "_busy_cycles"}, 32'(n), 32'(DEPTH));
        check({tag, "_quiet"}, {31'b0, quiet}, 32'h1);
        check({tag, "_busy_low"}, {31'b0, bus.busy}, 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; failures = 0; step = 0;
        reset_n = 1'b0;
        bus.mem_en = 1'b0; bus.mem_op = LW; bus.addr = '0; bus.wdata = '0; bus.pc = '0;
        model_reset();

        vecs[0]  = mk(1, LW,  32'h0000, 32'h0,         1, 0, 32'h0000_0000);
        vecs[1]  = mk(1, LW,  32'h3FFC, 32'h0,         1, 0, 32'h0000_0000);
        vecs[2]  = mk(1, LW,  32'h0010, 32'h0,         1, 0, 32'h0000_0000);
        vecs[3]  = mk(1, SW,  32'h0010, 32'h1234_5678, 0, 0, 32'h0000_0000);
        vecs[4]  = mk(1, LW,  32'h0010, 32'h0,         1, 0, 32'h1234_5678);
        vecs[5]  = mk(1, SH,  32'h0010, 32'h0000_AB78, 0, 0, 32'h1234_5678);
        vecs[6]  = mk(1, LW,  32'h0010, 32'h0,         1, 0, 32'h1234_AB78);
        vecs[7]  = mk(1, LB,  32'h0011, 32'h0,         1, 0, 32'hFFFF_FFAB);
        vecs[8]  = mk(1, LBU, 32'h0011, 32'h0,         1, 0, 32'h0000_00AB);
        vecs[9]  = mk(1, SH,  32'h0012, 32'h0000_8001, 0, 0, 32'h0000_00AB);
        vecs[10] = mk(1, LW,  32'h0010, 32'h0,         1, 0, 32'h8001_AB78);
        vecs[11] = mk(1, LH,  32'h0012, 32'h0,         1, 0, 32'hFFFF_8001);
        vecs[12] = mk(1, LHU, 32'h0012, 32'h0,         1, 0, 32'h0000_8001);
        vecs[13] = mk(1, LW,  32'h0012, 32'h0,         0, 1, 32'h0000_8001);
        vecs[14] = mk(1, SH,  32'h0013, 32'h0000_FFFF, 0, 1, 32'h0000_8001);
        vecs[15] = mk(1, LW,  32'h4000, 32'h0,         0, 1, 32'h0000_8001);
        vecs[16] = mk(1, SW,  32'h4000, 32'hFFFF_FFFF, 0, 1, 32'h0000_8001);
        vecs[17] = mk(1, RSV, 32'h0010, 32'hFFFF_FFFF, 0, 1, 32'h0000_8001);
        vecs[18] = mk(0, LW,  32'h0010, 32'h0,         0, 0, 32'h0000_8001);
        vecs[19] = mk(1, LW,  32'h0010, 32'h0,         1, 0, 32'h8001_AB78);
        vecs[20] = mk(1, SW,  32'h3FFC, 32'hCAFE_F00D, 0, 0, 32'h8001_AB78);
        vecs[21] = mk(1, LH,  32'h3FFE, 32'h0,         1, 0, 32'hFFFF_CAFE);
        vecs[22] = mk(1, LB,  32'h3FFC, 32'h0,         1, 0, 32'h0000_000D);
        vecs[23] = mk(1, LB,  32'h3FFF, 32'h0,         1, 0, 32'hFFFF_FFCA);
        vecs[24] = mk(1, LHU, 32'h0010, 32'h0,         1, 0, 32'h0000_AB78);
        vecs[25] = mk(1, LH,  32'h0010, 32'h0,         1, 0, 32'hFFFF_AB78);

        repeat (3) @(negedge clk);
        check("reset_rdata",    bus.rdata,              32'h0);
        check("reset_rvalid",   {31'b0, bus.rvalid},    32'h0);
        check("reset_addr_err", {31'b0, bus.addr_err},  32'h0);
        check("reset_busy",     {31'b0, bus.busy},      32'h1);

        reset_n = 1'b1;
        wait_clear("clear1");

        for (int i = 0; i < 26; i++) begin
            apply(vecs[i].en, vecs[i].op, vecs[i].addr, vecs[i].wdata);
            check($sformatf("vec%0d_rvalid", i),   {31'b0, bus.rvalid},   {31'b0, vecs[i].exp_valid});
            check($sformatf("vec%0d_addr_err", i), {31'b0, bus.addr_err}, {31'b0, vecs[i].exp_err});
            check($sformatf("vec%0d_rdata", i),    bus.rdata,             vecs[i].exp_rdata);
        end

        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            int          sel;
            sel = $urandom_range(0, 9);
            if (sel < 6)       a = 32'($urandom_range(0, 63));
            else if (sel < 8)  a = 32'h3FC0 + 32'($urandom_range(0, 63));
            else if (sel == 8) a = 32'h4000 + 32'($urandom_range(0, 7));
            else               a = $urandom;
            apply(($urandom_range(0, 9) != 0), 3'($urandom_range(0, 7)), a, $urandom);
            check($sformatf("rand%0d_rvalid", i),   {31'b0, bus.rvalid},   {31'b0, m_valid});
            check($sformatf("rand%0d_addr_err", i), {31'b0, bus.addr_err}, {31'b0, m_err});
            check($sformatf("rand%0d_rdata", i),    bus.rdata,             m_rdata);
        end

        // Reset lands between a load request and the edge that would return it.
        apply(1, SW, 32'h20, 32'h5A5A_5A5A);
        apply(1, LW, 32'h20, 32'h0);
        check("preload_rdata", bus.rdata, 32'h5A5A_5A5A);
        bus.mem_en = 1'b1; bus.mem_op = LW; bus.addr = 32'h20;
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("midload_rdata",  bus.rdata,           32'h0);
        check("midload_rvalid", {31'b0, bus.rvalid}, 32'h0);
        check("midload_busy",   {31'b0, bus.busy},   32'h1);
        @(negedge clk);
        check("midload_no_rvalid", {31'b0, bus.rvalid}, 32'h0);
        reset_n = 1'b1;
        wait_clear("clear2");

        // Reset partway through the clear must restart it from word 0.
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (100) @(negedge clk);
        check("midclear_busy", {31'b0, bus.busy}, 32'h1);
        reset_n = 1'b0;
        #1;
        check("midclear_rst_busy", {31'b0, bus.busy}, 32'h1);
        @(negedge clk);
        reset_n = 1'b1;
        wait_clear("clear3");

        apply(1, LW, 32'h20, 32'h0);
        check("post_clear_rvalid", {31'b0, bus.rvalid}, 32'h1);
        check("post_clear_rdata",  bus.rdata,           32'h0);
        apply(1, LW, 32'h3FFC, 32'h0);
        check("post_clear_top",    bus.rdata,           32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
